serial_negator: RTL and testbench

SERIAL_NEGATOR -- requirements
Module: serial_negator

---
 rtl/serial_neg_pkg.sv | 12 +
 rtl/neg_bit_cell.sv | 12 +
 rtl/serial_negator.sv | 103 ++++++++++
 tb/tb_serial_negator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_neg_pkg.sv
// Shared types and constants for the bit-serial two's-complement negator.
package serial_neg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/neg_bit_cell.sv
// One bit of serial negation: copy bits up to and including the first 1, invert the rest.
module neg_bit_cell (
    input  logic b,
    input  logic seen_in,
    output logic r,
    output logic seen_out
);

    assign r        = b ^ seen_in;
    assign seen_out = seen_in | b;

endmodule

// File: rtl/serial_negator.sv
// Bit-serial two's-complement negator, LSB first, one bit per clock.
// Define SERIAL_NEGATOR_OVF_EN to enable most-negative-operand detection on out_ovf.
module serial_negator
    import serial_neg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and data is held stable while valid waits for ready.
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             seen;
    logic             r;
    logic             seen_nxt;

    neg_bit_cell u_cell (
        .b       (sreg[0]),
        .seen_in (seen),
        .r       (r),
        .seen_out(seen_nxt)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            seen      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= in_data;
                        seen  <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB so the register holds the answer after WIDTH shifts.
                    sreg <= {r, sreg[WIDTH-1:1]};
                    seen <= seen_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= {r, sreg[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_NEGATOR_OVF_EN
    logic ovf_pend;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (state == IDLE && in_valid)
                ovf_pend <= (in_data == {1'b1, {(WIDTH-1){1'b0}}});
            if (state == SHIFT && cnt == LAST_BIT)
                ovf_q <= ovf_pend;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_negator.sv
// Self-checking bench for serial_negator at WIDTH=4; honours SERIAL_NEGATOR_OVF_EN.
module tb_serial_negator;

    localparam int W = 4;
`ifdef SERIAL_NEGATOR_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] exp_r;
        logic         exp_ovf;
        int           hold;
    } vec_t;

    vec_t vecs[7];

    serial_negator #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: negation modulo 2^W, overflow only for the most-negative operand
    function automatic logic [W:0] model(input int d);
        int   n;
        logic ovf;
        n   = ((1 << W) - d) % (1 << W);
        ovf = OVF_ON && (d == (1 << (W - 1)));
        return {ovf, W'(n)};
    endfunction

    // driver: one full transaction, returns result and handshake-to-valid latency
    task automatic do_op(input logic [W-1:0] d, input int hold,
                         output logic [W-1:0] r, output logic ovf, output int lat);
        int           guard;
        logic [W-1:0] held;
        logic         held_ovf;
        out_ready = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("wait_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        check("accept_in_ready_low", in_ready, 1'b0);
        check("accept_busy", busy, 1'b1);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid) check("shift_in_ready_low", in_ready, 1'b0);
        end
        check("out_valid_timeout", out_valid, 1'b1);
        r        = out_data;
        ovf      = out_ovf;
        held     = out_data;
        held_ovf = out_ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, held);
            check("hold_ovf", out_ovf, held_ovf);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("taken_valid_low", out_valid, 1'b0);
        check("taken_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] r;
        logic         ovf;
        logic [W:0]   e;
        int           lat;
        logic         saw_valid;

        vecs[0] = '{d: 4'b1101, exp_r: 4'b0011, exp_ovf: 1'b0,   hold: 0};
        vecs[1] = '{d: 4'b1001, exp_r: 4'b0111, exp_ovf: 1'b0,   hold: 1};
        vecs[2] = '{d: 4'b0000, exp_r: 4'b0000, exp_ovf: 1'b0,   hold: 0};
        vecs[3] = '{d: 4'b1000, exp_r: 4'b1000, exp_ovf: OVF_ON, hold: 2};
        vecs[4] = '{d: 4'b0110, exp_r: 4'b1010, exp_ovf: 1'b0,   hold: 10};
        vecs[5] = '{d: 4'b0111, exp_r: 4'b1001, exp_ovf: 1'b0,   hold: 0};
        vecs[6] = '{d: 4'b1111, exp_r: 4'b0001, exp_ovf: 1'b0,   hold: 3};

        // reset state
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_ovf", out_ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].d, vecs[i].hold, r, ovf, lat);
            check($sformatf("vec%0d_data", i), r, vecs[i].exp_r);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_latency", i), lat, W + 1);
        end

        // back-to-back: second operand waits with in_valid high until first result taken
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1001;
        @(posedge clk);
        #1;
        in_data = 4'b0000;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("b2b_not_accepted", in_ready, 1'b0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_data", out_data, 4'b0111);
        check("b2b_first_ovf", out_ovf, 1'b0);
        check("b2b_first_latency", lat, W + 1);
        @(posedge clk);
        #1;
        check("b2b_idle_between", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_second_accepted", busy, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_second_data", out_data, 4'b0000);
        check("b2b_second_ovf", out_ovf, 1'b0);
        check("b2b_second_latency", lat, W + 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_done", out_valid, 1'b0);

        // reset two cycles into SHIFT discards the operation
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0101;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state_idle", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_out_ovf", out_ovf, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        out_ready = 1'b0;
        check("midrst_no_result", saw_valid, 1'b0);
        do_op(4'b0001, 0, r, ovf, lat);
        check("postrst_data", r, 4'b1111);
        check("postrst_ovf", ovf, 1'b0);
        check("postrst_latency", lat, W + 1);

        // randomized against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] d;
            d = W'($urandom_range(0, (1 << W) - 1));
            exp_q.push_back(model(int'(d)));
            do_op(d, $urandom_range(0, 3), r, ovf, lat);
            e = exp_q.pop_front();
            check("rand_data", r, e[W-1:0]);
            check("rand_ovf", ovf, e[W]);
            check("rand_latency", lat, W + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
